// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: divider state encodings and handshake constants shared with the EX stage
package seq_divider_pkg;
  typedef enum logic [1:0] {
    DivFree   = 2'd0,
    DivByZero = 2'd1,
    DivOn     = 2'd2,
    DivEnd    = 2'd3
  } div_state_e;
  localparam logic        DivStart          = 1'b1;
  localparam logic        DivStop           = 1'b0;
  localparam logic        DivResultReady    = 1'b1;
  localparam logic        DivResultNotReady = 1'b0;
  localparam logic [31:0] ZeroWord          = 32'h0;
endpackage

// File: rtl/seq_divider_div_step.sv
// seq_divider_div_step: one combinational restoring division iteration
//   rem_i/dvd_i/dvs_i : partial remainder, remaining dividend bits, divisor magnitude
//   rem_o/dvd_o       : next partial remainder, dividend shifted left with quotient bit in LSB
module seq_divider_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] dvd_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] dvd_o
);
  logic [WIDTH:0] shifted, diff;
  logic           borrow;
  // The trial value is one bit wider than the divisor so the borrow lands in its MSB.
  assign shifted = {rem_i, dvd_i[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_i};
  assign borrow  = diff[WIDTH];
  assign rem_o   = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign dvd_o   = {dvd_i[WIDTH-2:0], ~borrow};
endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle radix-2 restoring signed/unsigned divider for the EX stage
//   clk, rst          : clock, synchronous active-high reset
//   signed_div_i      : 1 = signed (div), 0 = unsigned (divu)
//   opdata1_i/2_i     : dividend / divisor, captured when the request is accepted
//   start_i, annul_i  : request level held until ready_o; abort of an in-flight divide
//   result_o, ready_o : {remainder, quotient} and its valid flag, both registered
//   DIV_BYZERO_SAT_EN : when defined, x/0 yields quotient all-ones and remainder x
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);
  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, dvd_q, dvd_d, dvs_q, dvs_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic             ready_q, ready_d;
  logic [WIDTH-1:0] step_rem, step_dvd, bz_rem, bz_quo;
  logic             s1, s2;
  seq_divider_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .dvd_i (dvd_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .dvd_o (step_dvd)
  );
  assign s1 = signed_div_i & opdata1_i[WIDTH-1];
  assign s2 = signed_div_i & opdata2_i[WIDTH-1];
`ifdef DIV_BYZERO_SAT_EN
  logic [WIDTH-1:0] raw_q, raw_d;
  assign bz_rem = raw_q;
  assign bz_quo = '1;
`else
  assign bz_rem = WIDTH'(ZeroWord);
  assign bz_quo = WIDTH'(ZeroWord);
`endif
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    ready_d  = ready_q;
`ifdef DIV_BYZERO_SAT_EN
    raw_d    = raw_q;
`endif
    case (state_q)
      DivFree: if (start_i == DivStart && !annul_i) begin
        state_d = (opdata2_i == '0) ? DivByZero : DivOn;
        dvd_d   = s1 ? -opdata1_i : opdata1_i;
        dvs_d   = s2 ? -opdata2_i : opdata2_i;
        qneg_d  = s1 ^ s2;
        rneg_d  = s1;
        rem_d   = WIDTH'(ZeroWord);
        cnt_d   = '0;
`ifdef DIV_BYZERO_SAT_EN
        raw_d   = opdata1_i;
`endif
      end
      DivByZero: begin
        state_d  = DivEnd;
        ready_d  = DivResultReady;
        result_d = {bz_rem, bz_quo};
      end
      DivOn: if (annul_i) begin
        state_d = DivFree;
      end else begin
        rem_d = step_rem;
        dvd_d = step_dvd;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d  = DivEnd;
          ready_d  = DivResultReady;
          result_d = {rneg_q ? -step_rem : step_rem, qneg_q ? -step_dvd : step_dvd};
        end
      end
      DivEnd: if (start_i == DivStop) begin
        state_d  = DivFree;
        ready_d  = DivResultNotReady;
        result_d = {2{WIDTH'(ZeroWord)}};
      end
      default: state_d = DivFree;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DivFree;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= DivResultNotReady;
`ifdef DIV_BYZERO_SAT_EN
      raw_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      ready_q  <= ready_d;
`ifdef DIV_BYZERO_SAT_EN
      raw_q    <= raw_d;
`endif
    end
  end
  assign result_o = result_q;
  assign ready_o  = ready_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed scoreboard bench for seq_divider
module tb_seq_divider;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        signed_div = 1'b0;
  logic [31:0] op1 = '0, op2 = '0;
  logic        start = 1'b0, annul = 1'b0;
  logic [63:0] result;
  logic        ready;
  int          checks = 0, failures = 0;
  logic [63:0] exp_q[$];

  seq_divider dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input bit sd, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'h0) begin
`ifdef DIV_BYZERO_SAT_EN
      return {a, 32'hFFFF_FFFF};
`else
      return 64'h0;
`endif
    end
    if (!sd) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
  endfunction

  // Request a divide, wait for ready_o (bounded), compare latency and result,
  // optionally hold start for some cycles, then release and check the clear.
  task automatic run_div(input string tag, input bit sd, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int lat, input int hold, input bit scramble);
    int n = 0;
    logic [63:0] e;
    @(negedge clk);
    signed_div = sd; op1 = a; op2 = b; start = 1'b1;
    exp_q.push_back(exp);
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
      if (scramble && n == 3) begin
        op1 = $urandom; op2 = $urandom; signed_div = ~sd;
      end
    end
    e = exp_q.pop_front();
    chk({tag, "_latency"}, 64'(n), 64'(lat));
    chk({tag, "_result"}, result, e);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_ready"}, 64'(ready), 64'd1);
      chk({tag, "_hold_result"}, result, e);
    end
    start = 1'b0;
    @(negedge clk);
    chk({tag, "_drop_ready"}, 64'(ready), 64'd0);
    chk({tag, "_drop_result"}, result, 64'h0);
  endtask

  initial begin
    int seen;
    logic [31:0] ra, rb;
    repeat (2) @(negedge clk);
    chk("reset_ready", 64'(ready), 64'd0);
    chk("reset_result", result, 64'h0);
    rst = 1'b0;

    run_div("u100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 5, 1'b0);
    run_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 0, 1'b0);
    run_div("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 33, 0, 1'b0);
    run_div("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33, 0, 1'b0);
`ifdef DIV_BYZERO_SAT_EN
    run_div("dz_5_0", 1'b0, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 2, 2, 1'b0);
`else
    run_div("dz_5_0", 1'b0, 32'd5, 32'd0, 64'h0, 2, 2, 1'b0);
`endif
    run_div("scramble", 1'b0, 32'd1000, 32'd33, {32'd10, 32'd30}, 33, 0, 1'b1);

    // annul in ON cycle 10, then restart immediately
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
    repeat (10) @(negedge clk);
    annul = 1'b1; start = 1'b0;
    @(negedge clk);
    annul = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (ready) seen = 1;
      @(negedge clk);
    end
    chk("annul_no_ready", 64'(seen), 64'd0);
    chk("annul_result", result, 64'h0);
    run_div("u9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 0, 1'b0);

    // reset in the middle of a divide
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'h0001_2345; op2 = 32'd7; start = 1'b1;
    repeat (15) @(negedge clk);
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready", 64'(ready), 64'd0);
    chk("rst_mid_result", result, 64'h0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (ready) seen = 1;
      @(negedge clk);
    end
    chk("rst_mid_no_ready", 64'(seen), 64'd0);
    run_div("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'h0, 32'hFFFF_FFFF}, 33, 0, 1'b0);

    for (int k = 0; k < 4; k++) begin
      ra = $urandom;
      rb = $urandom_range(1, 1 << (k * 8));
      run_div("rand", k[0], ra, rb, model(k[0], ra, rb), 33, 0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle radix-2 restoring divider.
- Serves as the responder to the EX stage's divide requests.
- EX holds start_i high and stalls the pipeline until ready_o rises. It then reads the remainder/quotient pair and drops start_i.
- Sits beside the ALU and multiplier in the execute stage; supports the signed (div) and unsigned (divu) instructions.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- signed_div_i  in  1  1 = signed division, 0 = unsigned
- opdata1_i  in  WIDTH  dividend
- opdata2_i  in  WIDTH  divisor
- start_i  in  1  request level; held high by the initiator until ready_o is seen
- annul_i  in  1  abort an in-flight division
- result_o  out  2*WIDTH  {remainder[2W-1:W], quotient[W-1:0]}, registered
- ready_o  out  1  result valid, registered

Behaviour:
- Reset: rst is synchronous and active-high, clock is clk. Reset sets state=FREE, ready_o=0, result_o=0, counter=0 and clears internal registers. Reset mid-operation aborts silently.
- States: FREE, BYZERO, ON, END.
- FREE:
  - If start_i=1 and annul_i=0 with divisor==0, go to BYZERO.
  - If start_i=1 and annul_i=0 with divisor!=0, go to ON.
  - Otherwise stay in FREE.
  - On the transition, latch signed_div_i, the operand magnitudes (two's-complement abs when signed and MSB=1), the quotient sign (sign1^sign2) and the remainder sign (sign1). Clear the partial remainder and set counter=0.
- ON: one restoring step per cycle.
  - Shift {rem, dividend} left by 1 and trial-subtract the divisor from rem.
  - If non-negative, keep the difference and shift in quotient bit 1; otherwise keep rem and shift in 0.
  - counter increments each cycle. After the WIDTH-th step (counter==WIDTH-1), go to END.
  - annul_i=1 in any ON cycle: go to FREE next edge; result_o stays 0, ready_o stays 0.
- BYZERO: go to END next cycle with a zero result (see optional feature).
- END:
  - ready_o=1. result_o holds the sign-corrected quotient and remainder, written on the ON/BYZERO->END edge.
  - If start_i=0, go to FREE and clear ready_o and result_o to 0 on that edge.
  - If start_i stays 1, hold END with stable outputs.
- Latency: start sampled in cycle 0 (FREE), ON in cycles 1..WIDTH, ready_o=1 in cycle WIDTH+1 (33). Divide-by-zero gives ready_o in cycle 2.
- Operand changes after the FREE capture are ignored. annul_i in FREE, BYZERO or END has no effect.
- Signed corrections:
  - Quotient is negated if the quotient sign is set.
  - Remainder is negated if the dividend sign is set.
  - INT_MIN / -1 wraps: quotient 0x80000000, remainder 0.
- Widths: the partial remainder is WIDTH+1 bits to hold the borrow; all arithmetic is modulo 2^WIDTH.

Optional Feature:
- Macro: DIV_BYZERO_SAT_EN.
- Defined: divide-by-zero returns quotient all-ones and remainder = original dividend (raw opdata1_i bits).
- Undefined: divide-by-zero returns result_o = 0.
- Timing and handshake are identical in both cases.

Decomposition:
- Shared defines header carries: state encodings (DivFree, DivByZero, DivOn, DivEnd), DivStart/DivStop, DivResultReady/DivResultNotReady, ZeroWord. The EX stage uses the same constants.
- One natural sub-module: div_step. It is a combinational single restoring iteration that takes {rem, dividend, divisor} and returns {rem_next, dividend_next} with the quotient bit shifted in. The FSM, counter and sign handling stay in seq_divider.

Test Plan:
- Unsigned 100/7, start held: ready_o rises in cycle 33, result_o={32'd2, 32'd14}. Drop start_i: next cycle ready_o=0, result_o=0.
- Signed -7/2: quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7/-2: quotient 0xFFFFFFFD, remainder 1. Signed 0x80000000/0xFFFFFFFF: quotient 0x80000000, remainder 0.
- Divide-by-zero 5/0: ready_o in cycle 2. Result is 0 with the macro off; quotient 0xFFFFFFFF, remainder 5 with DIV_BYZERO_SAT_EN.
- annul_i pulsed in ON cycle 10: FREE next edge, ready_o never rises. An immediate new start of 9/3 completes with quotient 3, remainder 0.
- start_i held high for 5 cycles after ready_o: outputs stable in END. Operands changed during ON do not alter the result.
- rst asserted mid-ON: next edge state FREE, ready_o=0, result_o=0. A subsequent unsigned 0xFFFFFFFF/1 gives quotient 0xFFFFFFFF, remainder 0.
